// File: rtl/regfile_mp.sv
// Multi-read-port register file with a post-reset clear sweep and ready handshake.
// Define RF_BYPASS_EN to forward same-cycle write data to matching read ports.
`timescale 1ns/1ps
module regfile_mp #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_RD  = 2,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       regwrite,
    input  logic [ADDR_W-1:0]          addr_write_reg,
    input  logic [DATA_W-1:0]          write_data,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic                       ready,
    output logic                       wr_drop
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {INIT, RUN} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] clr_idx;
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= INIT;
            clr_idx <= '0;
            wr_drop <= 1'b0;
        end else begin
            state   <= state_next;
            wr_drop <= (state == INIT) && regwrite;
            if (state == INIT) clr_idx <= clr_idx + ADDR_W'(1);
        end
    end

    always_comb begin
        state_next = state;
        if (state == INIT && clr_idx == ADDR_W'(DEPTH - 1)) state_next = RUN;
    end

    always_comb begin
        ready = (state == RUN);
    end

    // NOTE: the array has no reset branch; the INIT sweep clears it so it can map onto RAM/flop arrays without reset fan-out.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[clr_idx] <= '0;
        end else if (regwrite && !(ZERO_R0 && addr_write_reg == '0)) begin
            mem[addr_write_reg] <= write_data;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              hit_zero;
        logic              bypass;

        assign ra       = rd_addr[k*ADDR_W +: ADDR_W];
        assign hit_zero = ZERO_R0 && (ra == '0);
`ifdef RF_BYPASS_EN
        assign bypass   = regwrite && (ra == addr_write_reg);
`else
        assign bypass   = 1'b0;
`endif
        assign rd_data[k*DATA_W +: DATA_W] = (state != RUN || hit_zero) ? '0 :
                                             bypass                     ? write_data :
                                                                          mem[ra];
    end
endmodule
